uart_rx: RTL and testbench
==========================

# uart_rx

115200 8N1 UART receiver, the receive-side counterpart of the board's UART transmitter, on the same 100 MHz clock and bit period of 868 cycles. It synchronises the asynchronous `uart_rxd` pin and detects and validates the start bit. It samples 8 data bits LSB-first at mid-bit and checks the stop bit. Each received byte goes into a one-entry holding register with a valid/ack handshake toward the PDU core, with framing-error and overrun reporting.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit; must be even and at least 8; benches may use 16.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `en`  in  1  receiver enable; low acts as a synchronous clear to the DISABLED state.
- `uart_rxd`  in  1  serial line, idle high, asynchronous to `clk`.
- `ack`  in  1  consumer has taken `data`; clears `valid` and `overrun`.
- `data`  out  8  last correctly framed byte; held until overwritten.
- `valid`  out  1  `data` holds an unacknowledged byte.
- `overrun`  out  1  sticky; a new byte overwrote an unacknowledged one.
- `frame_error`  out  1  one-cycle pulse; the stop bit was sampled low.

## Operation
- Synchroniser: 2-FF chain on `uart_rxd`, reset to 1. The FSM sees only the synchronised `rxd_s`.
- Counters: `counter` is 10 bits and `bits_counter` is 3 bits. `H = CLKS_PER_BIT/2`.
- States: DISABLED, IDLE, START, BITS, STOP, RECOVER.
- DISABLED: always moves to IDLE on the next cycle and clears the counters.
- IDLE: when `rxd_s == 0`, go to START with `counter = 0`.
- START: at `counter == H-1`, sample `rxd_s`.
  - If it is 1, treat it as a glitch: return to IDLE. No output changes.
  - If it is 0, go to BITS with `counter = 0` and `bits_counter = 0`.
  - Otherwise, increment `counter`.
- BITS: at `counter == CLKS_PER_BIT-1`, shift `rxd_s` into `shift[bits_counter]`, increment `bits_counter`, and reset `counter`. After bit 7, go to STOP.
- STOP: at `counter == CLKS_PER_BIT-1`, sample `rxd_s`.
  - If it is 1, load `data <= shift`, set `valid <= 1`, and go to IDLE.
  - If it is 0, pulse `frame_error` for one cycle, leave `data`/`valid` untouched, and go to RECOVER.
- RECOVER: wait for `rxd_s == 1`, then go to IDLE. A held-low break line therefore yields exactly one `frame_error` per break.
- Handshake:
  - `ack` with `valid == 1` clears both `valid` and `overrun` on the next edge.
  - `ack` while `valid == 0` has no effect.
- Simultaneous events:
  - Load with `valid == 1` and no `ack`: `data` is overwritten, `valid` stays 1, and `overrun <= 1`.
  - Load and `ack` in the same cycle: new `data` is loaded, `valid` stays 1, and `overrun` is cleared (no overrun).
- Reset mid-frame, from `rst` or `en` low:
  - State goes to DISABLED, all counters and `shift` to 0, and all outputs to 0. Synchroniser flops go to 1.
  - The partial byte is discarded. After release, a line that is still low is received as a new start bit only after passing START validation.

## Timing
- Reset values:
  - `data` = 0x00
  - `valid` = 0
  - `overrun` = 0
  - `frame_error` = 0
- The receiver is ready one cycle after `rst`/`en` release (DISABLED→IDLE).
- Let edge E0 be the first `clk` edge at which the pin is low. Then:
  - `rxd_s` is low at E2, and START is entered at E2.
  - Start is validated at E2+H-1.
  - Data bit i is sampled at E2 + H + i·CLKS_PER_BIT + CLKS_PER_BIT - 1.
  - The stop bit is sampled at E2 + H + 9·CLKS_PER_BIT - 1.
  - `valid`/`frame_error` become visible at E2 + H + 9·CLKS_PER_BIT, which is E0+8248 for the default parameters.
- The sample point is at mid-bit ±2 cycles, tolerating about ±4% baud mismatch.
- IDLE is re-entered at mid-stop-bit, so back-to-back frames with a single stop bit are received without loss.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single byte 0xA5 at the correct baud, `ack` held low → `data = 0xA5` and `valid` rises exactly 2+H+9·CLKS_PER_BIT cycles after E0. `valid` stays high; `ack` clears it the next cycle.
- Back-to-back 0x00, 0xFF, 0x3C, each acked within 10 cycles of `valid` → three loads in order, no `overrun`, no `frame_error`.
- Two frames 0x11 then 0x22 with no `ack` → `data = 0x22`, `valid = 1`, `overrun = 1`. A second case: `ack` coincides with the second load → `overrun` stays 0.
- Low glitch of H/2 cycles on an idle line → FSM returns to IDLE; `valid`, `frame_error` and `data` are unchanged.
- Frame 0x55 with the stop bit driven low, then the line held low for 3 bit times → exactly one `frame_error` pulse and no `valid`. The next good frame 0x81 is received correctly.
- Assert `rst` asynchronously mid-bit 4 of a frame → all outputs are 0 immediately. The following full frame 0xC3 is received correctly. Repeat with `en` deasserted for one cycle instead of `rst`.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake bundle between uart_rx and its consumer
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       overrun;
  logic       frame_error;
  logic       ack;

  modport master (output data, output valid, output overrun, output frame_error, input ack);
  modport slave  (input data, input valid, input overrun, input frame_error, output ack);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and one-entry valid/ack holding register
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      uart_rxd,
  uart_rx_if.master rx
);

  localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] HALF_LAST = 10'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    DISABLED,
    IDLE,
    START,
    BITS,
    STOP,
    RECOVER
  } state_t;

  state_t     state;
  logic [9:0] counter;
  logic [2:0] bits_counter;
  logic [7:0] shift;
  logic       rxd_meta;
  logic       rxd_s;
  logic [7:0] data_q;
  logic       valid_q;
  logic       overrun_q;
  logic       frame_error_q;

  // Flops park at the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else if (!en) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= DISABLED;
      counter       <= '0;
      bits_counter  <= '0;
      shift         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else if (!en) begin
      state         <= DISABLED;
      counter       <= '0;
      bits_counter  <= '0;
      shift         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      if (rx.ack && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state)
        DISABLED: begin
          state        <= IDLE;
          counter      <= '0;
          bits_counter <= '0;
        end
        IDLE: begin
          if (!rxd_s) begin
            state   <= START;
            counter <= '0;
          end
        end
        START: begin
          if (counter == HALF_LAST) begin
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              state        <= BITS;
              counter      <= '0;
              bits_counter <= '0;
            end
          end else begin
            counter <= counter + 10'd1;
          end
        end
        BITS: begin
          if (counter == BIT_LAST) begin
            shift[bits_counter] <= rxd_s;
            bits_counter        <= bits_counter + 3'd1;
            counter             <= '0;
            if (bits_counter == 3'd7) begin
              state <= STOP;
            end
          end else begin
            counter <= counter + 10'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit keeps back-to-back frames aligned.
          if (counter == BIT_LAST) begin
            if (rxd_s) begin
              data_q    <= shift;
              valid_q   <= 1'b1;
              overrun_q <= valid_q & ~rx.ack;
              state     <= IDLE;
            end else begin
              frame_error_q <= 1'b1;
              state         <= RECOVER;
            end
          end else begin
            counter <= counter + 10'd1;
          end
        end
        RECOVER: begin
          if (rxd_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= DISABLED;
        end
      endcase
    end
  end

  assign rx.data        = data_q;
  assign rx.valid       = valid_q;
  assign rx.overrun     = overrun_q;
  assign rx.frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: timing, handshake, framing, glitch, reset cases
module tb_uart_rx;

  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int LAT = 2 + H + 9 * C;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic uart_rxd;
  logic ack;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   fe_pulses = 0;
  int   last_rise = 0;
  int   last_e0   = 0;
  int   frames_started = 0;
  bit   valid_d  = 1'b0;
  bit   abort    = 1'b0;

  uart_rx_if bus ();
  assign bus.ack = ack;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .uart_rxd (uart_rxd),
    .rx       (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_error) fe_pulses++;
    if (bus.valid && !valid_d) last_rise = cyc;
    valid_d = bus.valid;
  end

  typedef struct {
    logic [7:0] byte_in;
    bit         stop_ok;
    bit         ack_after;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_overrun;
    int         exp_fe;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    @(negedge clk);
    last_e0 = cyc + 1;
    frames_started++;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      for (int k = 0; k < C; k++) begin
        @(negedge clk);
        if (abort) begin
          uart_rxd = 1'b1;
          return;
        end
      end
    end
    uart_rxd = 1'b1;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    int t;
    t = 0;
    while (!bus.valid && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    ok = bus.valid;
  endtask

  task automatic reset_midframe(input bit use_rst, input string tag);
    int base;
    int t;
    int fe_base;
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    chk({tag, "_pre_overrun"}, 32'(bus.overrun), 32'd1);
    base = frames_started;
    t = 0;
    fork
      send_frame(8'h99, 1'b1);
      begin
        while (frames_started == base && t < 4) begin
          @(negedge clk);
          t++;
        end
        while (cyc < last_e0 + 5 * C + H) @(negedge clk);
        if (use_rst) begin
          #2 rst = 1'b1;
          #1;
        end else begin
          en = 1'b0;
          @(negedge clk);
        end
        chk({tag, "_data"}, 32'(bus.data), 32'h0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
        chk({tag, "_frame_error"}, 32'(bus.frame_error), 32'd0);
        abort = 1'b1;
        if (use_rst) begin
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
        end else begin
          en = 1'b1;
        end
      end
    join
    abort = 1'b0;
    repeat (2 * C) @(negedge clk);
    fe_base = fe_pulses;
    send_frame(8'hC3, 1'b1);
    repeat (C) @(negedge clk);
    chk({tag, "_after_data"}, 32'(bus.data), 32'hC3);
    chk({tag, "_after_valid"}, 32'(bus.valid), 32'd1);
    chk({tag, "_after_overrun"}, 32'(bus.overrun), 32'd0);
    chk({tag, "_after_fe"}, 32'(fe_pulses - fe_base), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got[$];
    logic [7:0] m_data;
    bit         m_valid;
    bit         m_overrun;
    logic [7:0] rb;
    bit         rstop;
    bit         ok;
    int         fe_base;
    int         base;
    int         t;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1};
    vecs[6] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 0};
    vecs[7] = '{8'h7E, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1};
    vecs[8] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 0};

    uart_rxd = 1'b1;
    ack      = 1'b0;
    en       = 1'b1;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(bus.data), 32'h0);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_overrun", 32'(bus.overrun), 32'd0);
    chk("reset_frame_error", 32'(bus.frame_error), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    chk("a5_latency", 32'(last_rise - last_e0), 32'(LAT));
    chk("a5_data", 32'(bus.data), 32'hA5);
    repeat (20) @(negedge clk);
    chk("a5_valid_held", 32'(bus.valid), 32'd1);
    ack_pulse();
    chk("a5_ack_clears", 32'(bus.valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      fe_base = fe_pulses;
      send_frame(vecs[i].byte_in, vecs[i].stop_ok);
      repeat (C) @(negedge clk);
      chk($sformatf("vec%0d_data", i), 32'(bus.data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_overrun", i), 32'(bus.overrun), 32'(vecs[i].exp_overrun));
      chk($sformatf("vec%0d_fe", i), 32'(fe_pulses - fe_base), 32'(vecs[i].exp_fe));
      if (vecs[i].ack_after) ack_pulse();
    end

    // Back-to-back frames, each acknowledged a few cycles after valid.
    ack_pulse();
    fe_base = fe_pulses;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_valid(12 * C, ok);
          chk($sformatf("b2b%0d_arrived", k), 32'(ok), 32'd1);
          chk($sformatf("b2b%0d_overrun", k), 32'(bus.overrun), 32'd0);
          got.push_back(bus.data);
          repeat (5) @(negedge clk);
          ack = 1'b1;
          @(negedge clk);
          ack = 1'b0;
        end
      end
    join
    chk("b2b_byte0", 32'(got[0]), 32'h00);
    chk("b2b_byte1", 32'(got[1]), 32'hFF);
    chk("b2b_byte2", 32'(got[2]), 32'h3C);
    chk("b2b_fe", 32'(fe_pulses - fe_base), 32'd0);

    // Ack landing on the very edge that loads the second byte.
    base = frames_started;
    t = 0;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        while (frames_started < base + 2 && t < 30 * C) begin
          @(negedge clk);
          t++;
        end
        while (cyc < last_e0 + LAT - 1) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    repeat (C) @(negedge clk);
    chk("coincide_data", 32'(bus.data), 32'h22);
    chk("coincide_valid", 32'(bus.valid), 32'd1);
    chk("coincide_overrun", 32'(bus.overrun), 32'd0);
    ack_pulse();

    fe_base = fe_pulses;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (H / 2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * C) @(negedge clk);
    chk("glitch_valid", 32'(bus.valid), 32'd0);
    chk("glitch_data", 32'(bus.data), 32'h22);
    chk("glitch_fe", 32'(fe_pulses - fe_base), 32'd0);
    send_frame(8'h5A, 1'b1);
    repeat (C) @(negedge clk);
    chk("after_glitch_data", 32'(bus.data), 32'h5A);
    ack_pulse();

    fe_base = fe_pulses;
    send_frame(8'h55, 1'b0);
    uart_rxd = 1'b0;
    repeat (3 * C) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (C) @(negedge clk);
    chk("break_fe_count", 32'(fe_pulses - fe_base), 32'd1);
    chk("break_valid", 32'(bus.valid), 32'd0);
    chk("break_data", 32'(bus.data), 32'h5A);
    send_frame(8'h81, 1'b1);
    repeat (C) @(negedge clk);
    chk("after_break_data", 32'(bus.data), 32'h81);
    chk("after_break_valid", 32'(bus.valid), 32'd1);

    reset_midframe(1'b1, "rst_mid");
    reset_midframe(1'b0, "en_mid");

    // Randomised frames against a byte-level holding-register model.
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    m_data    = 8'h00;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      fe_base = fe_pulses;
      send_frame(rb, rstop);
      repeat ($urandom_range(3, C)) @(negedge clk);
      if (rstop) begin
        m_overrun = m_overrun | m_valid;
        m_data    = rb;
        m_valid   = 1'b1;
      end
      chk($sformatf("rand%0d_data", i), 32'(bus.data), 32'(m_data));
      chk($sformatf("rand%0d_valid", i), 32'(bus.valid), 32'(m_valid));
      chk($sformatf("rand%0d_overrun", i), 32'(bus.overrun), 32'(m_overrun));
      chk($sformatf("rand%0d_fe", i), 32'(fe_pulses - fe_base), rstop ? 32'd0 : 32'd1);
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        if (m_valid) begin
          m_valid   = 1'b0;
          m_overrun = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
